// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop, LSB first.
// {Carry_Out, Sum_Out} = A + B + Carry_In after DATA_WIDTH shift cycles;
// Overflow_Out flags two's-complement overflow of the same add.
module serial_adder #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  Clock_In,
  input  logic                  Reset_In,
  input  logic                  Start_In,
  input  logic [DATA_WIDTH-1:0] Data_A_In,
  input  logic [DATA_WIDTH-1:0] Data_B_In,
  input  logic                  Carry_In,
  output logic                  Busy_Out,
  output logic                  Done_Out,
  output logic [DATA_WIDTH-1:0] Sum_Out,
  output logic                  Carry_Out,
  output logic                  Overflow_Out
);

  localparam int unsigned CntWidth = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntWidth-1:0] LastBit = CntWidth'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [DATA_WIDTH-1:0] b_q, b_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic                  carry_q, carry_d;
  logic                  cout_q, cout_d;
  logic                  ovf_q, ovf_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  bit_sum, bit_carry;

  // Full-adder cell, FSM next state and datapath next state.
  always_comb begin
    bit_sum   = a_q[0] ^ b_q[0] ^ carry_q;
    bit_carry = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (Start_In) begin
          a_d     = Data_A_In;
          b_d     = Data_B_In;
          carry_d = Carry_In;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        carry_d             = bit_carry;
        acc_d               = acc_q >> 1;
        acc_d[DATA_WIDTH-1] = bit_sum;
        a_d                 = a_q >> 1;
        b_d                 = b_q >> 1;
        cnt_d               = cnt_q + CntWidth'(1);
        if (cnt_q == LastBit) begin
          // carry_q still holds the carry into the MSB on this edge.
          sum_d   = acc_d;
          cout_d  = bit_carry;
          ovf_d   = carry_q ^ bit_carry;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Busy_Out     = (state_q != StIdle);
  assign Done_Out     = (state_q == StDone);
  assign Sum_Out      = sum_q;
  assign Carry_Out    = cout_q;
  assign Overflow_Out = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at DATA_WIDTH 8, 1 and 13.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start8, cin8, busy8, done8, cout8, ovf8;
  logic [7:0]  a8, b8, sum8;
  logic        start1, cin1, busy1, done1, cout1, ovf1;
  logic [0:0]  a1, b1, sum1;
  logic        start13, cin13, busy13, done13, cout13, ovf13;
  logic [12:0] a13, b13, sum13;

  serial_adder #(.DATA_WIDTH(8)) dut8 (
    .Clock_In(clk), .Reset_In(rst), .Start_In(start8), .Data_A_In(a8), .Data_B_In(b8),
    .Carry_In(cin8), .Busy_Out(busy8), .Done_Out(done8), .Sum_Out(sum8),
    .Carry_Out(cout8), .Overflow_Out(ovf8)
  );
  serial_adder #(.DATA_WIDTH(1)) dut1 (
    .Clock_In(clk), .Reset_In(rst), .Start_In(start1), .Data_A_In(a1), .Data_B_In(b1),
    .Carry_In(cin1), .Busy_Out(busy1), .Done_Out(done1), .Sum_Out(sum1),
    .Carry_Out(cout1), .Overflow_Out(ovf1)
  );
  serial_adder #(.DATA_WIDTH(13)) dut13 (
    .Clock_In(clk), .Reset_In(rst), .Start_In(start13), .Data_A_In(a13), .Data_B_In(b13),
    .Carry_In(cin13), .Busy_Out(busy13), .Done_Out(done13), .Sum_Out(sum13),
    .Carry_Out(cout13), .Overflow_Out(ovf13)
  );

  typedef logic [17:0] res_t;  // {carry, overflow, sum zero-extended to 16}

  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  res_t exp8[$], obs8[$], exp1[$], obs1[$], exp13[$], obs13[$];
  int   t8[$];

  // Reference: plain integer add, overflow from operand/result signs.
  function automatic res_t model(int w, logic [15:0] a, logic [15:0] b, logic cin);
    logic [16:0] full;
    logic [15:0] mask, sa, sb, s;
    logic        co, ov;
    mask = 16'((17'd1 << w) - 17'd1);
    sa   = a & mask;
    sb   = b & mask;
    full = {1'b0, sa} + {1'b0, sb} + 17'(cin);
    s    = full[15:0] & mask;
    co   = full[w];
    ov   = (sa[w-1] == sb[w-1]) && (s[w-1] != sa[w-1]);
    return {co, ov, s};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Capture results as each DUT signals completion.
  always @(negedge clk) begin
    if (done8) begin
      obs8.push_back({cout8, ovf8, 8'h00, sum8});
      t8.push_back(cyc);
    end
    if (done1)  obs1.push_back({cout1, ovf1, 15'h0, sum1});
    if (done13) obs13.push_back({cout13, ovf13, 3'h0, sum13});
  end

  task automatic pop8(output res_t e, output res_t o, output bit have);
    have = (obs8.size() > 0) && (exp8.size() > 0);
    e = '0; o = '1;
    if (have) begin e = exp8.pop_front(); o = obs8.pop_front(); end
  endtask

  task automatic pop1(output res_t e, output res_t o, output bit have);
    have = (obs1.size() > 0) && (exp1.size() > 0);
    e = '0; o = '1;
    if (have) begin e = exp1.pop_front(); o = obs1.pop_front(); end
  endtask

  task automatic pop13(output res_t e, output res_t o, output bit have);
    have = (obs13.size() > 0) && (exp13.size() > 0);
    e = '0; o = '1;
    if (have) begin e = exp13.pop_front(); o = obs13.pop_front(); end
  endtask

  // One add on the 8-bit DUT; returns done latency and busy cycle count.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      output int lat, output int busy_n);
    @(negedge clk);
    a8 = a; b8 = b; cin8 = cin; start8 = 1'b1;
    exp8.push_back(model(8, 16'(a), 16'(b), cin));
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    lat = -1; busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy8) busy_n++;
      if (done8 && lat < 0) lat = i;
      if (!busy8) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++; if (sum8 !== 8'h00) begin fails++; $display("FAIL reset_sum: got %h want 00", sum8); end
    tests++; if (cout8 !== 1'b0) begin fails++; $display("FAIL reset_cout: got %b want 0", cout8); end
    tests++; if (ovf8 !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", ovf8); end
    tests++; if (busy8 !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy8); end
    tests++; if (done8 !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done8); end
    tests++;
    if ({busy1, busy13, sum1, sum13} !== '0) begin
      fails++; $display("FAIL reset_other: got %b want 0", {busy1, busy13, sum1, sum13});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bn; res_t e, o; bit h;
    run8(8'h5A, 8'h33, 1'b0, lat, bn);
    tests++; if (lat != 8) begin fails++; $display("FAIL basic_latency: got %0d want 8", lat); end
    tests++; if (bn != 9) begin fails++; $display("FAIL basic_busy_cycles: got %0d want 9", bn); end
    pop8(e, o, h);
    tests++; if (!h || o !== e) begin fails++; $display("FAIL basic_result: got %h want %h", o, e); end
  endtask

  task automatic test_carry();
    int lat, bn; res_t e, o; bit h;
    run8(8'hFF, 8'h01, 1'b0, lat, bn);
    pop8(e, o, h);
    tests++; if (!h || o !== e) begin fails++; $display("FAIL carry_ff01: got %h want %h", o, e); end
    run8(8'h80, 8'h80, 1'b0, lat, bn);
    pop8(e, o, h);
    tests++; if (!h || o !== e) begin fails++; $display("FAIL carry_8080: got %h want %h", o, e); end
  endtask

  task automatic test_hold();
    int lat, bn; res_t e, o; bit h;
    run8(8'h7F, 8'h00, 1'b1, lat, bn);
    pop8(e, o, h);
    tests++; if (!h || o !== e) begin fails++; $display("FAIL hold_result: got %h want %h", o, e); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom);
      tests++;
      if (sum8 !== 8'h80) begin fails++; $display("FAIL hold_sum: cycle %0d got %h want 80", i, sum8); end
    end
  endtask

  task automatic test_ignore();
    int dn; res_t e, o; bit h;
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    exp8.push_back(model(8, 16'h10, 16'h20, 1'b0));
    @(negedge clk);
    start8 = 1'b0;
    dn = 0;
    for (int i = 0; i < 24; i++) begin
      if (done8) dn++;
      if (i == 2 || i == 7) begin start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; end
      else start8 = 1'b0;
      @(negedge clk);
    end
    tests++; if (dn != 1) begin fails++; $display("FAIL ignore_done_count: got %0d want 1", dn); end
    tests++; if (busy8 !== 1'b0) begin fails++; $display("FAIL ignore_busy: got %b want 0", busy8); end
    pop8(e, o, h);
    tests++; if (!h || o !== e) begin fails++; $display("FAIL ignore_result: got %h want %h", o, e); end
    tests++; if (obs8.size() != 0) begin fails++; $display("FAIL ignore_extra: got %0d want 0", obs8.size()); end
  endtask

  task automatic test_reset_abort();
    int lat, bn, base; res_t e, o; bit h;
    @(negedge clk);
    a8 = 8'h55; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({sum8, cout8, ovf8, busy8, done8} !== 12'h000) begin
      fails++; $display("FAIL abort_outputs: got %h want 000", {sum8, cout8, ovf8, busy8, done8});
    end
    base = obs8.size();
    repeat (12) @(negedge clk);
    tests++; if (obs8.size() != base) begin fails++; $display("FAIL abort_done: got %0d want %0d", obs8.size(), base); end
    run8(8'h01, 8'h02, 1'b0, lat, bn);
    tests++; if (lat != 8) begin fails++; $display("FAIL abort_latency: got %0d want 8", lat); end
    pop8(e, o, h);
    tests++; if (!h || o !== e) begin fails++; $display("FAIL abort_result: got %h want %h", o, e); end
  endtask

  task automatic test_back_to_back();
    int wt; res_t e, o; bit h;
    t8.delete();
    wt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); start8 = 1'b1;
      if (wt == 0) begin
        exp8.push_back(model(8, 16'(a8), 16'(b8), cin8));
        wt = 9;
      end else begin
        wt--;
      end
    end
    @(negedge clk);
    start8 = 1'b0;
    repeat (15) @(negedge clk);
    tests++; if (t8.size() != 4) begin fails++; $display("FAIL b2b_count: got %0d want 4", t8.size()); end
    for (int i = 0; i + 1 < t8.size(); i++) begin
      tests++;
      if (t8[i+1] - t8[i] != 10) begin
        fails++; $display("FAIL b2b_period: got %0d want 10", t8[i+1] - t8[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      pop8(e, o, h);
      tests++; if (!h || o !== e) begin fails++; $display("FAIL b2b_result %0d: got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_random();
    logic [15:0] ra, rb; logic rc; res_t e, o; bit h, idle;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      a8 = ra[7:0]; b8 = rb[7:0]; cin8 = rc; start8 = 1'b1;
      exp8.push_back(model(8, ra, rb, rc));
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      a1 = ra[0]; b1 = rb[0]; cin1 = rc; start1 = 1'b1;
      exp1.push_back(model(1, ra, rb, rc));
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      a13 = ra[12:0]; b13 = rb[12:0]; cin13 = rc; start13 = 1'b1;
      exp13.push_back(model(13, ra, rb, rc));
      @(negedge clk);
      start8 = 1'b0; start1 = 1'b0; start13 = 1'b0;
      idle = 1'b0;
      for (int i = 0; i < 40; i++) begin
        if (!busy1 && !busy8 && !busy13) begin idle = 1'b1; break; end
        @(negedge clk);
      end
      if (!idle) begin
        tests++; fails++; $display("FAIL rand_timeout: op %0d still busy", n);
      end
      pop1(e, o, h);
      tests++; if (!h || o !== e) begin fails++; $display("FAIL rand_w1 %0d: got %h want %h", n, o, e); end
      pop8(e, o, h);
      tests++; if (!h || o !== e) begin fails++; $display("FAIL rand_w8 %0d: got %h want %h", n, o, e); end
      pop13(e, o, h);
      tests++; if (!h || o !== e) begin fails++; $display("FAIL rand_w13 %0d: got %h want %h", n, o, e); end
    end
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    start13 = 1'b0; a13 = '0; b13 = '0; cin13 = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_hold();
    test_ignore();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
